// File: rtl/sn76489_pkg.sv
// rtl/sn76489_pkg.sv - shared constants for the SN76489-style noise and tone channels
package sn76489_pkg;

  // Noise shift rate select
  typedef enum logic [1:0] {
    RATE_16    = 2'b00,
    RATE_32    = 2'b01,
    RATE_64    = 2'b10,
    RATE_TONE2 = 2'b11
  } rate_e;

  // Enables per shift for the fixed rates; follow-tone-2 mode parks at 16
  localparam logic [9:0] N_RATE_16 = 10'd16;
  localparam logic [9:0] N_RATE_32 = 10'd32;
  localparam logic [9:0] N_RATE_64 = 10'd64;

  // Feedback type select
  localparam logic PERIODIC    = 1'b0;
  localparam logic WHITE_NOISE = 1'b1;

  // Attenuation code that silences the channel
  localparam logic [3:0] ATT_OFF = 4'hF;

  // 2 dB per step full-scale magnitudes, entry 15 is silence
  localparam logic [15:0] AMP_ROM [16] = '{
    16'd32767, 16'd26027, 16'd20674, 16'd16422,
    16'd13044, 16'd10361, 16'd8230,  16'd6537,
    16'd5193,  16'd4125,  16'd3276,  16'd2602,
    16'd2067,  16'd1642,  16'd1304,  16'd0
  };

  // Reload value of the shift-rate counter for a rate code
  function automatic logic [9:0] rate_to_n(input logic [1:0] r);
    case (rate_e'(r))
      RATE_32: rate_to_n = N_RATE_32;
      RATE_64: rate_to_n = N_RATE_64;
      default: rate_to_n = N_RATE_16;
    endcase
  endfunction

endpackage

// File: rtl/sn76489_attenuator.sv
// rtl/sn76489_attenuator.sv - attenuation code plus sign to signed sample
module sn76489_attenuator
  import sn76489_pkg::*;
#(
  parameter int OUT_WIDTH = 16
) (
  input  logic [3:0]                  att,
  input  logic                        positive,
  output logic signed [OUT_WIDTH-1:0] amp
);

  logic [15:0]          mag_full;
  logic [OUT_WIDTH-1:0] mag;

  // Narrower outputs keep the top bits, i.e. an arithmetic shift of a positive value
  assign mag_full = AMP_ROM[att];
  assign mag      = mag_full[15 -: OUT_WIDTH];

  // Apply the sign, with the off code forcing silence
  always_comb begin
    amp = '0;
    if (att != ATT_OFF) begin
      amp = positive ? $signed(mag) : -$signed(mag);
    end
  end

endmodule

// File: rtl/sn76489_noise_channel.sv
// rtl/sn76489_noise_channel.sv - parametrised PSG noise channel with rate select and reseed
module sn76489_noise_channel
  import sn76489_pkg::*;
#(
  parameter int          LFSR_WIDTH = 16,
  parameter logic [15:0] WHITE_TAPS = 16'h0009,
  parameter int          OUT_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        enable,
  input  logic                        noiseWrite,
  input  logic [1:0]                  rate,
  input  logic                        noiseFeedbackType,
  input  logic [3:0]                  att,
  input  logic                        tone2Tick,
  output logic signed [OUT_WIDTH-1:0] out
);

  localparam logic [LFSR_WIDTH-1:0] SEED     = {1'b1, {(LFSR_WIDTH-1){1'b0}}};
  localparam logic [LFSR_WIDTH-1:0] TAP_MASK = WHITE_TAPS[LFSR_WIDTH-1:0];

  logic [LFSR_WIDTH-1:0] lfsr;
  logic [9:0]            counter;
  logic                  follow_tone2;
  logic                  shift_tick;
  logic                  fb;

  // Pick the shift source and the feedback bit for the current mode
  always_comb begin
    follow_tone2 = (rate == RATE_TONE2);
    shift_tick   = follow_tone2 ? tone2Tick : (enable && (counter <= 10'd1));
    fb           = (noiseFeedbackType == PERIODIC) ? lfsr[0] : ^(lfsr & TAP_MASK);
  end

  // Rate counter and shift register; a register write reseeds and wins over a tick
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr    <= SEED;
      counter <= rate_to_n(rate);
    end else if (noiseWrite) begin
      lfsr    <= SEED;
      counter <= rate_to_n(rate);
    end else begin
      if (!follow_tone2 && enable) begin
        counter <= (counter <= 10'd1) ? rate_to_n(rate) : counter - 10'd1;
      end
      if (shift_tick) begin
        lfsr <= (lfsr == '0) ? SEED : {fb, lfsr[LFSR_WIDTH-1:1]};
      end
    end
  end

  sn76489_attenuator #(
    .OUT_WIDTH(OUT_WIDTH)
  ) u_attenuator (
    .att     (att),
    .positive(lfsr[0]),
    .amp     (out)
  );

endmodule

// File: tb/tb_sn76489_noise_channel.sv
// tb/tb_sn76489_noise_channel.sv - self-checking bench for the noise channel
module tb_sn76489_noise_channel;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              enable;
  logic              noiseWrite;
  logic [1:0]        rate;
  logic              noiseFeedbackType;
  logic [3:0]        att;
  logic              tone2Tick;
  logic signed [15:0] out16;
  logic signed [7:0]  out8;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  // Model state: per-instance register contents, enables since reload, reload length
  int m_lfsr [2];
  int m_ecnt;
  int m_nload;
  localparam int MW  [2] = '{16, 15};
  localparam int MOW [2] = '{16, 8};

  always #5 clk = ~clk;

  sn76489_noise_channel #(
    .LFSR_WIDTH(16), .WHITE_TAPS(16'h0009), .OUT_WIDTH(16)
  ) dut16 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .noiseWrite(noiseWrite),
    .rate(rate), .noiseFeedbackType(noiseFeedbackType), .att(att),
    .tone2Tick(tone2Tick), .out(out16)
  );

  sn76489_noise_channel #(
    .LFSR_WIDTH(15), .WHITE_TAPS(16'h0009), .OUT_WIDTH(8)
  ) dut15 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .noiseWrite(noiseWrite),
    .rate(rate), .noiseFeedbackType(noiseFeedbackType), .att(att),
    .tone2Tick(tone2Tick), .out(out8)
  );

  function automatic int period_of(input logic [1:0] r);
    case (r)
      2'd1:    return 32;
      2'd2:    return 64;
      default: return 16;
    endcase
  endfunction

  function automatic int amp_model(input int k, input int ow);
    int full;
    full = $rtoi($floor(32767.0 * (10.0 ** (-k / 10.0))));
    return full >> (16 - ow);
  endfunction

  function automatic int next_state(input int s, input int w, input bit white);
    int fb;
    int mask;
    mask = (1 << w) - 1;
    if (s == 0) return 1 << (w - 1);
    fb = white ? ($countones(s & 32'h0009 & mask) % 2) : (s & 1);
    return (s >> 1) | (fb << (w - 1));
  endfunction

  function automatic int exp_out(input int i);
    int a;
    if (att == 4'hF) return 0;
    a = amp_model(int'(att), MOW[i]);
    return ((m_lfsr[i] & 1) != 0) ? a : -a;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one shift per N enables, tone-2 mode, reseed on write
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n || noiseWrite) begin
      for (int i = 0; i < 2; i++) m_lfsr[i] <= 1 << (MW[i] - 1);
      m_ecnt  <= 0;
      m_nload <= period_of(rate);
    end else if (rate == 2'd3) begin
      if (tone2Tick)
        for (int i = 0; i < 2; i++) m_lfsr[i] <= next_state(m_lfsr[i], MW[i], noiseFeedbackType);
    end else if (enable) begin
      if (m_ecnt + 1 >= m_nload) begin
        for (int i = 0; i < 2; i++) m_lfsr[i] <= next_state(m_lfsr[i], MW[i], noiseFeedbackType);
        m_ecnt  <= 0;
        m_nload <= period_of(rate);
      end else begin
        m_ecnt <= m_ecnt + 1;
      end
    end
  end

  // Compare both instances against the model every cycle
  always @(negedge clk) begin
    if (chk_on) begin
      check("model_w16", int'(out16), exp_out(0));
      check("model_w15", int'(out8), exp_out(1));
    end
  end

  task automatic tick_en(input int n);
    repeat (n) begin
      enable = 1'b1;
      @(posedge clk); #1;
      enable = 1'b0;
      repeat (3) @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic [1:0] r, input logic f, input logic [3:0] a);
    reset_n = 1'b0;
    rate = r; noiseFeedbackType = f; att = a;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; noiseWrite = 1'b0; rate = 2'd1;
    noiseFeedbackType = 1'b0; att = 4'hF; tone2Tick = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk_on = 1'b1;
    check("rst_att_off", int'(out16), 0);
    att = 4'd1; #1;
    check("rst_att1_w16", int'(out16), -26027);
    check("rst_att1_w15", int'(out8), -101);
    att = 4'hF;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Silent channel
    tick_en(32);
    check("t1_silent", int'(out16), 0);

    // Periodic, N=32, att=1
    do_reset(2'd1, 1'b0, 4'd1);
    tick_en(448);
    check("t2_448_w16", int'(out16), -26027);
    check("t2_448_w15", int'(out8), 101);
    tick_en(32);
    check("t2_480_w16", int'(out16), 26027);
    check("t2_480_w15", int'(out8), -101);
    tick_en(32);
    check("t2_512_w16", int'(out16), -26027);
    tick_en(448);
    check("t2_960_w16", int'(out16), -26027);
    tick_en(32);
    check("t2_992_w16", int'(out16), 26027);
    tick_en(32);
    check("t2_1024_w16", int'(out16), -26027);

    // White noise, N=64, att=8
    do_reset(2'd2, 1'b1, 4'd8);
    tick_en(959);
    check("t3_959", int'(out16), -5193);
    tick_en(1);
    check("t3_960", int'(out16), 5193);
    tick_en(64);
    check("t3_1024", int'(out16), -5193);
    tick_en(1024);

    // Register write coincident with the 480th enable swallows the 15th shift
    do_reset(2'd1, 1'b0, 4'd1);
    tick_en(479);
    enable = 1'b1; noiseWrite = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0; noiseWrite = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t4_no_shift", int'(out16), -26027);
    tick_en(479);
    check("t4_pre", int'(out16), -26027);
    tick_en(1);
    check("t4_post", int'(out16), 26027);

    // Follow tone 2 with enable held high
    rate = 2'd3; att = 4'd0; noiseFeedbackType = 1'b0; noiseWrite = 1'b1;
    @(posedge clk); #1;
    noiseWrite = 1'b0;
    enable = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      repeat (2) @(posedge clk);
      #1;
      if (i == 15) check("t5_before15", int'(out16), -32767);
      tone2Tick = 1'b1;
      @(posedge clk); #1;
      tone2Tick = 1'b0;
    end
    check("t5_after15", int'(out16), 32767);
    enable = 1'b0;
    rate = 2'd0;
    @(posedge clk); #1;
    tick_en(15);
    check("t5_frozen", int'(out16), 32767);
    tick_en(1);
    check("t5_reload", int'(out16), -32767);

    // Asynchronous reset in the high phase
    do_reset(2'd0, 1'b0, 4'd1);
    tick_en(240);
    check("t6_high", int'(out16), 26027);
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    check("t6_async_w16", int'(out16), -26027);
    check("t6_async_w15", int'(out8), -101);
    @(posedge clk); #1;
    reset_n = 1'b1;
    tick_en(16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
